mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single off-chip Data_Memory port between two cache controllers: port 0 (icache controller) and port 1 (dcache_controller).
- Sits between the controllers' mem_* interfaces and Data_Memory.
- Serializes whole-line transactions and holds each grant until the memory acknowledges.
- Returns read data and a one-cycle ack to the winner. Inserts a one-cycle release gap so Data_Memory never sees back-to-back enables from a stale request.

Parameters:
ADDR_W, 32, address width of requests and memory port
DATA_W, 256, cache-line width carried on every data bus

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
p0_enable_i  in  1  port 0 request valid; held high until p0_ack_o
p0_write_i  in  1  port 0 request is write (1) / read (0)
p0_addr_i  in  ADDR_W  port 0 line address
p0_data_i  in  DATA_W  port 0 write line
p0_ack_o  out  1  port 0 completion pulse
p0_data_o  out  DATA_W  port 0 read line, valid with p0_ack_o
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o  same as port 0, for port 1
mem_enable_o  out  1  Data_Memory enable
mem_write_o  out  1  Data_Memory write
mem_addr_o  out  ADDR_W  Data_Memory address
mem_data_o  out  DATA_W  Data_Memory write line
mem_ack_i  in  1  Data_Memory completion pulse
mem_data_i  in  DATA_W  Data_Memory read line
grant_o  out  2  one-hot current owner; 00 when idle

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high on rst_i; clock is clk_i.
- Outputs: all registered. Reset values are 0 for every output. State=IDLE, last_grant=port 0.
- States: IDLE, BUSY, RELEASE.
- IDLE, when any pX_enable_i is high:
  - pick a winner and latch its write/addr/data into mem_write_o/mem_addr_o/mem_data_o;
  - set mem_enable_o=1 and grant_o=winner;
  - go to BUSY.
  - Latency: request seen at cycle N gives mem_enable_o high at N+1.
- Arbitration (default): fixed priority, port 1 (dcache) beats port 0.
- BUSY:
  - mem_* held stable. The loser's request is ignored and stays pending.
  - On mem_ack_i:
    - mem_enable_o←0;
    - winner's pX_ack_o←1 for exactly one cycle;
    - pX_data_o←mem_data_i (captured for reads; for writes, data_o content is don't-care but still loaded);
    - go to RELEASE.
- RELEASE:
  - Exactly one cycle. grant_o←00; all acks←0.
  - The just-served port's enable is ignored this cycle, because the requester drops it one cycle after ack.
  - No new grant in RELEASE. Next state is IDLE.
  - Minimum spacing between a mem_ack_i and the next mem_enable_o rise is 2 cycles.
- pX_data_o: holds the last captured value until the next ack to that port.
- mem_ack_i outside BUSY: ignored, with no ack and no state change.
- Requester drops enable while in BUSY (protocol violation): the memory transaction still completes, and the ack is still pulsed to that port.
- Reset mid-transaction (any state): the next cycle is IDLE with every output 0. A pending ack is discarded. Requesters must re-issue.
- Requests sampled only in IDLE. A simultaneous request in IDLE and reset resolves to reset.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - on simultaneous requests in IDLE, the port not equal to last_grant wins;
  - last_grant updates on every grant;
  - reset value of last_grant is port 0, so the first tie goes to port 1.
  - A single requester always wins regardless of last_grant.
- Undefined: fixed priority, port 1 always wins ties, and the last_grant register is not built.

Test Plan:
- Single read, port 0: p0 addr=0x0000_0400 held; Data_Memory acks after 10 cycles with 0xA5..A5.
  - Expected: mem_enable_o rises 1 cycle after request, mem_addr_o=0x400, mem_write_o=0.
  - Expected: p0_ack_o pulses 1 cycle after mem_ack_i with p0_data_o=0xA5..A5, grant_o 01 then 00.
- Single write, port 1: addr=0x0000_0020, data=0x1234..; memory line updated.
  - Expected: p1_ack_o one pulse, mem_write_o=1 throughout BUSY, no p0_ack_o.
- Simultaneous requests, default build: both raised same cycle.
  - Expected: port 1 served first; port 0 granted exactly 2 cycles after the first mem_ack_i; two distinct mem_enable_o pulses.
- Simultaneous requests held continuously, MEM_ARB_ROUND_ROBIN_EN defined.
  - Expected: grant sequence 1,0,1,0 over 4 transactions.
  - Same stimulus without the macro: 1,1,1,1 while p1 keeps re-requesting after each RELEASE.
- Reset in BUSY: assert rst_i 3 cycles after grant, before mem_ack_i.
  - Expected: next cycle all outputs 0, state IDLE; a later stray mem_ack_i produces no pX_ack_o.
- Stale-enable guard: port 0 holds enable one cycle past its ack.
  - Expected: no second grant during RELEASE; a regrant occurs only if enable is still high in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one Data_Memory port between the icache (port 0) and
// dcache (port 1) controllers. Whole-line transactions are serialized, the grant
// is held until mem_ack_i, and a one-cycle RELEASE gap follows every transaction.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
// Without it, port 1 wins every tie.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e              state_q, state_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [1:0]          grant_q, grant_d;
  logic                p0_ack_q, p0_ack_d;
  logic                p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0]   p0_data_q, p0_data_d;
  logic [DATA_W-1:0]   p1_data_q, p1_data_d;
  logic                sel_p1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 0: port 0 was granted last, 1: port 1 was granted last
  logic last_grant_q, last_grant_d;

  // Tie goes to the port that did not win last time; a lone requester always wins
  always_comb begin
    sel_p1 = p1_enable_i;
    if (p0_enable_i && p1_enable_i) begin
      sel_p1 = ~last_grant_q;
    end
  end

  // Remember the owner of every new grant
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == StIdle && (p0_enable_i || p1_enable_i)) begin
      last_grant_d = sel_p1;
    end
  end

  // Round-robin history register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: the dcache port wins whenever it requests
  always_comb begin
    sel_p1 = p1_enable_i;
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    grant_d      = grant_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_data_d    = p0_data_q;
    p1_data_d    = p1_data_q;

    unique case (state_q)
      StIdle: begin
        if (p0_enable_i || p1_enable_i) begin
          mem_enable_d = 1'b1;
          mem_write_d  = sel_p1 ? p1_write_i : p0_write_i;
          mem_addr_d   = sel_p1 ? p1_addr_i  : p0_addr_i;
          mem_data_d   = sel_p1 ? p1_data_i  : p0_data_i;
          grant_d      = sel_p1 ? 2'b10 : 2'b01;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        // Ack goes to the owner even if it dropped its enable meanwhile
        if (mem_ack_i) begin
          mem_enable_d = 1'b0;
          if (grant_q[1]) begin
            p1_ack_d  = 1'b1;
            p1_data_d = mem_data_i;
          end else begin
            p0_ack_d  = 1'b1;
            p0_data_d = mem_data_i;
          end
          state_d = StRelease;
        end
      end
      StRelease: begin
        // Requester's enable may still be high here; it is deliberately ignored
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      grant_q      <= 2'b00;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_data_q    <= '0;
      p1_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      grant_q      <= grant_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_data_q    <= p0_data_d;
      p1_data_q    <= p1_data_d;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign grant_o      = grant_q;
  assign p0_ack_o     = p0_ack_q;
  assign p1_ack_o     = p1_ack_q;
  assign p0_data_o    = p0_data_q;
  assign p1_data_o    = p1_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 256;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              p0_enable_i, p0_write_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_data_i;
  logic              p0_ack_o;
  logic [DATA_W-1:0] p0_data_o;
  logic              p1_enable_i, p1_write_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_data_i;
  logic              p1_ack_o;
  logic [DATA_W-1:0] p1_data_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [1:0]        grant_o;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  localparam logic [DATA_W-1:0] LineA5 = {32{8'hA5}};
  localparam logic [DATA_W-1:0] LineWr = {8{32'h12345678}};
  localparam logic [DATA_W-1:0] LineC3 = {32{8'hC3}};

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .p0_enable_i (p0_enable_i),
    .p0_write_i  (p0_write_i),
    .p0_addr_i   (p0_addr_i),
    .p0_data_i   (p0_data_i),
    .p0_ack_o    (p0_ack_o),
    .p0_data_o   (p0_data_o),
    .p1_enable_i (p1_enable_i),
    .p1_write_i  (p1_write_i),
    .p1_addr_i   (p1_addr_i),
    .p1_data_i   (p1_data_i),
    .p1_ack_o    (p1_ack_o),
    .p1_data_o   (p1_data_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i),
    .grant_o     (grant_o)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".mem_en"}, DATA_W'(mem_enable_o), '0);
    check({tag, ".grant"}, DATA_W'(grant_o), '0);
    check({tag, ".p0_ack"}, DATA_W'(p0_ack_o), '0);
    check({tag, ".p1_ack"}, DATA_W'(p1_ack_o), '0);
  endtask

  logic [1:0] exp_seq [4];
  logic [DATA_W-1:0] wr_line;
  bit seen;

  initial begin
    rst_i = 1'b1;
    p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
    tick(); tick();

    // Reset state
    check_idle_outputs("rst");
    check("rst.mem_addr", DATA_W'(mem_addr_o), '0);
    check("rst.mem_wr", DATA_W'(mem_write_o), '0);
    check("rst.p0_data", p0_data_o, '0);
    rst_i = 1'b0;

    // Single read on port 0, memory answers after 10 cycles
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h0000_0400;
    tick();
    check("rd.mem_en", DATA_W'(mem_enable_o), 1);
    check("rd.mem_addr", DATA_W'(mem_addr_o), 32'h400);
    check("rd.mem_wr", DATA_W'(mem_write_o), 0);
    check("rd.grant", DATA_W'(grant_o), 2'b01);
    for (int i = 0; i < 9; i++) tick();
    check("rd.hold_en", DATA_W'(mem_enable_o), 1);
    check("rd.no_early_ack", DATA_W'(p0_ack_o), 0);
    mem_ack_i = 1; mem_data_i = LineA5;
    tick();
    mem_ack_i = 0; mem_data_i = '0; p0_enable_i = 0;
    check("rd.p0_ack", DATA_W'(p0_ack_o), 1);
    check("rd.p0_data", p0_data_o, LineA5);
    check("rd.mem_en_off", DATA_W'(mem_enable_o), 0);
    check("rd.grant_ack", DATA_W'(grant_o), 2'b01);
    tick();
    check("rd.ack_pulse", DATA_W'(p0_ack_o), 0);
    check("rd.grant_rel", DATA_W'(grant_o), 2'b00);
    tick();

    // Single write on port 1
    p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h0000_0020; p1_data_i = LineWr;
    tick();
    check("wr.grant", DATA_W'(grant_o), 2'b10);
    check("wr.mem_addr", DATA_W'(mem_addr_o), 32'h20);
    for (int i = 0; i < 3; i++) begin
      check("wr.mem_wr", DATA_W'(mem_write_o), 1);
      tick();
    end
    wr_line = mem_write_o ? mem_data_o : '0;
    check("wr.line", wr_line, LineWr);
    mem_ack_i = 1; mem_data_i = LineC3;
    tick();
    mem_ack_i = 0; p1_enable_i = 0; p1_write_i = 0;
    check("wr.p1_ack", DATA_W'(p1_ack_o), 1);
    check("wr.no_p0_ack", DATA_W'(p0_ack_o), 0);
    check("wr.p0_data_hold", p0_data_o, LineA5);
    tick(); tick();
    check_idle_outputs("wr.after");

    // Simultaneous requests, served one after the other
    p0_enable_i = 1; p0_addr_i = 32'h0000_0400;
    p1_enable_i = 1; p1_addr_i = 32'h0000_0020;
    tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("tie.grant1", DATA_W'(grant_o), 2'b01);
`else
    check("tie.grant1", DATA_W'(grant_o), 2'b10);
    check("tie.addr1", DATA_W'(mem_addr_o), 32'h20);
    mem_ack_i = 1; mem_data_i = LineC3;
    tick();
    mem_ack_i = 0; p1_enable_i = 0;
    check("tie.p1_ack", DATA_W'(p1_ack_o), 1);
    tick();
    check("tie.release_en", DATA_W'(mem_enable_o), 0);
    check("tie.release_grant", DATA_W'(grant_o), 2'b00);
    tick();
    check("tie.grant2", DATA_W'(grant_o), 2'b01);
    check("tie.en2", DATA_W'(mem_enable_o), 1);
    check("tie.addr2", DATA_W'(mem_addr_o), 32'h400);
`endif
    mem_ack_i = 1;
    tick();
    mem_ack_i = 0; p0_enable_i = 0; p1_enable_i = 0;
    tick(); tick();

    // Continuous requests on both ports, four transactions from a fresh reset
    rst_i = 1; tick(); rst_i = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    p0_enable_i = 1; p1_enable_i = 1;
    for (int t = 0; t < 4; t++) begin
      seen = 0;
      for (int w = 0; w < 6 && !seen; w++) begin
        tick();
        seen = mem_enable_o;
      end
      check($sformatf("seq.en%0d", t), DATA_W'(seen), 1);
      check($sformatf("seq.grant%0d", t), DATA_W'(grant_o), DATA_W'(exp_seq[t]));
      mem_ack_i = 1;
      tick();
      mem_ack_i = 0;
    end
    p0_enable_i = 0; p1_enable_i = 0;
    tick(); tick();

    // Reset three cycles into BUSY, then a stray memory ack
    p0_enable_i = 1; p0_addr_i = 32'h0000_0400;
    tick();
    check("rstb.grant", DATA_W'(grant_o), 2'b01);
    tick(); tick(); tick();
    rst_i = 1;
    tick();
    rst_i = 0; p0_enable_i = 0;
    check_idle_outputs("rstb");
    check("rstb.p0_data", p0_data_o, '0);
    mem_ack_i = 1; mem_data_i = LineA5;
    tick();
    mem_ack_i = 0;
    tick();
    check_idle_outputs("stray");
    check("stray.p0_data", p0_data_o, '0);

    // Stale enable held one cycle past ack: no regrant
    p0_enable_i = 1;
    tick();
    mem_ack_i = 1;
    tick();
    mem_ack_i = 0;
    check("stale.ack", DATA_W'(p0_ack_o), 1);
    tick();
    check("stale.rel_en", DATA_W'(mem_enable_o), 0);
    p0_enable_i = 0;
    tick();
    check("stale.no_regrant", DATA_W'(mem_enable_o), 0);
    check("stale.grant", DATA_W'(grant_o), 2'b00);

    // Enable still high in IDLE: regrant
    p0_enable_i = 1;
    tick();
    mem_ack_i = 1;
    tick();
    mem_ack_i = 0;
    tick();
    check("regrant.rel_en", DATA_W'(mem_enable_o), 0);
    tick();
    check("regrant.en", DATA_W'(mem_enable_o), 1);
    check("regrant.grant", DATA_W'(grant_o), 2'b01);

    // Requester drops enable in BUSY: ack still delivered
    p0_enable_i = 0;
    tick();
    mem_ack_i = 1; mem_data_i = LineC3;
    tick();
    mem_ack_i = 0;
    check("drop.ack", DATA_W'(p0_ack_o), 1);
    check("drop.data", p0_data_o, LineC3);
    tick(); tick();
    check_idle_outputs("end");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
